// File: rtl/immediate_extend_pipe.sv
// immediate_extend_pipe: decode-stage immediate generator (RV32/RV64) with a 2-entry skid buffer.
// Define IMMEDIATE_EXTEND_ZICSR_EN to decode SYSTEM CSR-immediate (zimm) forms as type Z.
module immediate_extend_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instruction,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_immediate,
    output logic [2:0]       o_immType,
    output logic             o_illegal,
    output logic [TAG_W-1:0] o_tag,
    input  logic             i_clearCount,
    output logic [15:0]      o_illegalCount
);

    // Handshake: a beat moves on a rising edge where valid && ready are both high; the
    // sender holds its payload until then, and o_ready depends only on registered state.

    localparam logic [2:0] TYPE_NONE = 3'd0;
    localparam logic [2:0] TYPE_I    = 3'd1;
    localparam logic [2:0] TYPE_S    = 3'd2;
    localparam logic [2:0] TYPE_B    = 3'd3;
    localparam logic [2:0] TYPE_U    = 3'd4;
    localparam logic [2:0] TYPE_J    = 3'd5;
`ifdef IMMEDIATE_EXTEND_ZICSR_EN
    localparam logic [2:0] TYPE_Z    = 3'd6;
`endif

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_OP32     = 7'b0111011;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       imm_type;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    // ------------------------------------------------------------------
    // Format extraction: each raw field is signed at its natural width so
    // the size cast below sign-extends from the format's top bit.
    // ------------------------------------------------------------------
    logic [6:0]         opcode;
    logic signed [11:0] raw_i;
    logic signed [11:0] raw_s;
    logic signed [12:0] raw_b;
    logic signed [31:0] raw_u;
    logic signed [20:0] raw_j;

    assign opcode = i_instruction[6:0];
    assign raw_i  = i_instruction[31:20];
    assign raw_s  = {i_instruction[31:25], i_instruction[11:7]};
    assign raw_b  = {i_instruction[31], i_instruction[7], i_instruction[30:25],
                     i_instruction[11:8], 1'b0};
    assign raw_u  = {i_instruction[31:12], 12'b0};
    assign raw_j  = {i_instruction[31], i_instruction[19:12], i_instruction[20],
                     i_instruction[30:21], 1'b0};

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    assign imm_i = XLEN'(raw_i);
    assign imm_s = XLEN'(raw_s);
    assign imm_b = XLEN'(raw_b);
    assign imm_u = XLEN'(raw_u);
    assign imm_j = XLEN'(raw_j);

`ifdef IMMEDIATE_EXTEND_ZICSR_EN
    // zimm is the rs1 field, zero-extended; funct3 == 0 is ECALL/EBREAK/xRET.
    logic [4:0]      zimm;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_z;

    assign zimm   = i_instruction[19:15];
    assign funct3 = i_instruction[14:12];
    assign imm_z  = XLEN'(zimm);
`endif

    // ------------------------------------------------------------------
    // Opcode classification
    // ------------------------------------------------------------------
    entry_t dec_entry;

    always_comb begin
        dec_entry          = '0;
        dec_entry.tag      = i_tag;
        dec_entry.imm_type = TYPE_NONE;
        dec_entry.illegal  = 1'b0;
        dec_entry.imm      = '0;
        case (opcode)
            OP_LOAD, OP_MISC_MEM, OP_OP_IMM, OP_JALR: begin
                dec_entry.imm_type = TYPE_I;
                dec_entry.imm      = imm_i;
            end
            OP_OP_IMM32: begin
                if (XLEN == 64) begin
                    dec_entry.imm_type = TYPE_I;
                    dec_entry.imm      = imm_i;
                end else begin
                    dec_entry.illegal  = 1'b1;
                end
            end
            OP_STORE: begin
                dec_entry.imm_type = TYPE_S;
                dec_entry.imm      = imm_s;
            end
            OP_BRANCH: begin
                dec_entry.imm_type = TYPE_B;
                dec_entry.imm      = imm_b;
            end
            OP_LUI, OP_AUIPC: begin
                dec_entry.imm_type = TYPE_U;
                dec_entry.imm      = imm_u;
            end
            OP_JAL: begin
                dec_entry.imm_type = TYPE_J;
                dec_entry.imm      = imm_j;
            end
            OP_OP: begin
                dec_entry.imm_type = TYPE_NONE;
            end
            OP_OP32: begin
                if (XLEN != 64) begin
                    dec_entry.illegal = 1'b1;
                end
            end
            OP_SYSTEM: begin
`ifdef IMMEDIATE_EXTEND_ZICSR_EN
                if (funct3 != 3'b000) begin
                    dec_entry.imm_type = TYPE_Z;
                    dec_entry.imm      = imm_z;
                end
`else
                dec_entry.imm_type = TYPE_NONE;
`endif
            end
            default: begin
                dec_entry.illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Two-entry buffer: main drives the outputs, skid catches the one beat
    // accepted while main is stalled.
    // ------------------------------------------------------------------
    logic   main_valid;
    logic   skid_valid;
    entry_t main_q;
    entry_t skid_q;
    logic   accept;
    logic   transfer;

    assign o_ready  = ~skid_valid;
    assign accept   = i_valid & ~skid_valid;
    assign transfer = main_valid & i_ready;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (transfer) begin
            // accept cannot coincide with a full skid, since o_ready is low then
            if (skid_valid) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q     <= dec_entry;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            if (main_valid) begin
                skid_q     <= dec_entry;
                skid_valid <= 1'b1;
            end else begin
                main_q     <= dec_entry;
                main_valid <= 1'b1;
            end
        end
    end

    assign o_valid     = main_valid;
    assign o_immediate = main_q.imm;
    assign o_immType   = main_q.imm_type;
    assign o_illegal   = main_q.illegal;
    assign o_tag       = main_q.tag;

    // ------------------------------------------------------------------
    // Saturating illegal-opcode counter; clear wins over increment.
    // ------------------------------------------------------------------
    logic [15:0] illegal_count;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            illegal_count <= '0;
        end else if (i_clearCount) begin
            illegal_count <= '0;
        end else if (accept && dec_entry.illegal && (illegal_count != 16'hFFFF)) begin
            illegal_count <= illegal_count + 16'd1;
        end
    end

    assign o_illegalCount = illegal_count;

endmodule

// File: tb/tb_immediate_extend_pipe.sv
// Self-checking bench for immediate_extend_pipe: an XLEN=32 and an XLEN=64 instance share stimulus;
// a behavioural immediate model feeds a scoreboard. Honours IMMEDIATE_EXTEND_ZICSR_EN like the DUT.
module tb_immediate_extend_pipe;

    logic        i_clk = 1'b0;
    logic        i_arst_n = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] i_instruction = '0;
    logic [31:0] i_tag = '0;
    logic        i_ready = 1'b0;
    logic        i_clearCount = 1'b0;

    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_immediate;
    logic [2:0]  o_immType;
    logic        o_illegal;
    logic [31:0] o_tag;
    logic [15:0] o_illegalCount;

    logic        w_ready;
    logic        w_valid;
    logic [63:0] w_immediate;
    logic [2:0]  w_immType;
    logic        w_illegal;
    logic [31:0] w_tag;
    logic [15:0] w_illegalCount;

    always #5 i_clk = ~i_clk;

    immediate_extend_pipe #(.XLEN(32), .TAG_W(32)) dut (
        .i_clk(i_clk), .i_arst_n(i_arst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_instruction(i_instruction), .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready),
        .o_immediate(o_immediate), .o_immType(o_immType), .o_illegal(o_illegal),
        .o_tag(o_tag), .i_clearCount(i_clearCount), .o_illegalCount(o_illegalCount)
    );

    immediate_extend_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .i_clk(i_clk), .i_arst_n(i_arst_n), .i_valid(i_valid), .o_ready(w_ready),
        .i_instruction(i_instruction), .i_tag(i_tag), .o_valid(w_valid), .i_ready(i_ready),
        .o_immediate(w_immediate), .o_immType(w_immType), .o_illegal(w_illegal),
        .o_tag(w_tag), .i_clearCount(i_clearCount), .o_illegalCount(w_illegalCount)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    typedef struct {
        longint     imm;
        logic [2:0] ty;
        logic       ill;
    } ref_t;

    function automatic ref_t ref_model(input logic [31:0] inst, input bit rv64);
        ref_t   r;
        longint v;
        r.imm = 0;
        r.ty  = 3'd0;
        r.ill = 1'b0;
        case (inst[6:0])
            7'h03, 7'h0F, 7'h13, 7'h67: begin
                v = longint'(inst[31:20]);
                if (v >= 2048) v -= 4096;
                r.imm = v; r.ty = 3'd1;
            end
            7'h1B: begin
                if (rv64) begin
                    v = longint'(inst[31:20]);
                    if (v >= 2048) v -= 4096;
                    r.imm = v; r.ty = 3'd1;
                end else r.ill = 1'b1;
            end
            7'h23: begin
                v = longint'({inst[31:25], inst[11:7]});
                if (v >= 2048) v -= 4096;
                r.imm = v; r.ty = 3'd2;
            end
            7'h63: begin
                v = longint'({inst[31], inst[7], inst[30:25], inst[11:8]}) * 2;
                if (v >= 4096) v -= 8192;
                r.imm = v; r.ty = 3'd3;
            end
            7'h37, 7'h17: begin
                v = longint'(inst[31:12]) * 4096;
                if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000;
                r.imm = v; r.ty = 3'd4;
            end
            7'h6F: begin
                v = longint'({inst[31], inst[19:12], inst[20], inst[30:21]}) * 2;
                if (v >= 64'sd1048576) v -= 64'sd2097152;
                r.imm = v; r.ty = 3'd5;
            end
            7'h33: ;
            7'h3B: if (!rv64) r.ill = 1'b1;
            7'h73: begin
`ifdef IMMEDIATE_EXTEND_ZICSR_EN
                if (inst[14:12] != 3'b000) begin
                    r.imm = longint'(inst[19:15]);
                    r.ty  = 3'd6;
                end
`endif
            end
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    logic [67:0] exp_q[$];
    logic [67:0] got_q[$];
    logic [63:0] exp64_q[$];
    logic [63:0] got64_q[$];
    logic [15:0] exp_cnt = '0;
    bit          sb_en = 1'b1;

    always @(negedge i_clk) begin
        ref_t        r32;
        ref_t        r64;
        logic [63:0] u32;
        logic [63:0] u64;
        if (!i_arst_n) begin
            exp_cnt = '0;
        end else begin
            r32 = ref_model(i_instruction, 1'b0);
            r64 = ref_model(i_instruction, 1'b1);
            u32 = r32.imm;
            u64 = r64.imm;
            if (i_clearCount) exp_cnt = '0;
            else if (i_valid && o_ready && r32.ill && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            if (sb_en) begin
                if (o_valid && i_ready) got_q.push_back({o_tag, o_illegal, o_immType, o_immediate});
                if (w_valid && i_ready) got64_q.push_back(w_immediate);
                if (i_valid && o_ready) begin
                    exp_q.push_back({i_tag, r32.ill, r32.ty, u32[31:0]});
                    exp64_q.push_back(u64);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_one(input logic [31:0] inst, input logic [31:0] tag);
        bit done = 1'b0;
        i_valid = 1'b1; i_instruction = inst; i_tag = tag;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge i_clk);
            done = o_ready;
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: tag %0d not accepted within 20 cycles", tag);
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        i_valid = 1'b0; i_ready = 1'b1;
        for (int k = 0; k < 30 && !done; k++) begin
            @(posedge i_clk); #1;
            done = !o_valid && (got_q.size() == exp_q.size());
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: got %0d entries, expected %0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic clear_queues();
        exp_q.delete(); got_q.delete(); exp64_q.delete(); got64_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 i_arst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_valid, o_ready, o_immediate, o_immType, o_illegal, o_tag, o_illegalCount} !==
            {1'b0, 1'b1, 32'h0, 3'd0, 1'b0, 32'h0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_values: valid=%0b ready=%0b imm=%h type=%0d ill=%0b tag=%h cnt=%h, need 0,1,0,0,0,0,0",
                     o_valid, o_ready, o_immediate, o_immType, o_illegal, o_tag, o_illegalCount);
        end
        repeat (3) @(posedge i_clk);
        @(negedge i_clk) i_arst_n = 1'b1;
        @(posedge i_clk); #1;
        clear_queues();
    endtask

    task automatic test_load_branch();
        i_ready = 1'b1;
        send_one(32'hFFC12083, 32'd10);
        @(negedge i_clk);
        n_checks++;
        if ({o_valid, o_immediate, o_immType, o_illegal} !== {1'b1, 32'hFFFFFFFC, 3'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL load_imm32: valid=%0b imm=%h type=%0d, need 1 FFFFFFFC 1", o_valid, o_immediate, o_immType);
        end
        n_checks++;
        if (w_immediate !== 64'hFFFFFFFF_FFFFFFFC) begin
            n_fail++;
            $display("FAIL load_imm64: imm=%h, need FFFFFFFFFFFFFFFC", w_immediate);
        end
        @(posedge i_clk); #1;
        send_one(32'hFE000CE3, 32'd11);
        @(negedge i_clk);
        n_checks++;
        if ({o_valid, o_immediate, o_immType} !== {1'b1, 32'hFFFFFFF8, 3'd3}) begin
            n_fail++;
            $display("FAIL branch_imm: valid=%0b imm=%h type=%0d, need 1 FFFFFFF8 3", o_valid, o_immediate, o_immType);
        end
        drain();
        clear_queues();
    endtask

    task automatic test_store_u_j();
        logic [31:0] insts [4];
        logic [31:0] imms  [4];
        logic [2:0]  tys   [4];
        insts = '{32'h00512423, 32'h123450B7, 32'h001000EF, 32'h002081B3};
        imms  = '{32'h00000008, 32'h12345000, 32'h00000800, 32'h00000000};
        tys   = '{3'd2, 3'd4, 3'd5, 3'd0};
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send_one(insts[k], 32'd20 + k);
            @(negedge i_clk);
            n_checks++;
            if ({o_valid, o_immediate, o_immType, o_illegal, o_tag} !== {1'b1, imms[k], tys[k], 1'b0, 32'd20 + k}) begin
                n_fail++;
                $display("FAIL store_u_j[%0d]: valid=%0b imm=%h type=%0d ill=%0b tag=%0d, need 1 %h %0d 0 %0d",
                         k, o_valid, o_immediate, o_immType, o_illegal, o_tag, imms[k], tys[k], 20 + k);
            end
            @(posedge i_clk); #1;
        end
        drain();
        clear_queues();
    endtask

    task automatic test_illegal();
        i_ready = 1'b1;
        send_one(32'h00000000, 32'd30);
        @(negedge i_clk);
        n_checks++;
        if ({o_valid, o_illegal, o_immType, o_immediate, o_illegalCount} !== {1'b1, 1'b1, 3'd0, 32'h0, 16'd1}) begin
            n_fail++;
            $display("FAIL illegal_first: valid=%0b ill=%0b type=%0d imm=%h cnt=%0d, need 1 1 0 0 1",
                     o_valid, o_illegal, o_immType, o_immediate, o_illegalCount);
        end
        @(posedge i_clk); #1;
        sb_en = 1'b0;
        i_valid = 1'b1; i_instruction = 32'h0000_0000;
        repeat (65533) @(posedge i_clk);
        @(negedge i_clk);
        n_checks++;
        if (o_illegalCount !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL illegal_near_sat: cnt=%h, need FFFE", o_illegalCount);
        end
        repeat (4) @(posedge i_clk);
        #1 i_valid = 1'b0;
        @(negedge i_clk);
        n_checks++;
        if (o_illegalCount !== 16'hFFFF || exp_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL illegal_sat: cnt=%h model=%h, need FFFF", o_illegalCount, exp_cnt);
        end
        @(posedge i_clk); #1;
        i_clearCount = 1'b1;
        send_one(32'h0000_0000, 32'd31);
        i_clearCount = 1'b0;
        @(negedge i_clk);
        n_checks++;
        if (o_illegalCount !== 16'h0) begin
            n_fail++;
            $display("FAIL clear_with_illegal: cnt=%h, need 0", o_illegalCount);
        end
        @(posedge i_clk); #1;
        send_one(32'hFFFF_FFFC, 32'd32);
        @(negedge i_clk);
        n_checks++;
        if (o_illegalCount !== 16'h1 || o_illegal !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_low_bits: cnt=%h ill=%0b, need 1 1", o_illegalCount, o_illegal);
        end
        drain();
        sb_en = 1'b1;
        clear_queues();
    endtask

    task automatic test_backpressure();
        logic [31:0] insts [4];
        logic [67:0] e;
        logic [67:0] g;
        insts = '{32'hFFC12083, 32'h00512423, 32'h123450B7, 32'h001000EF};
        clear_queues();
        i_ready = 1'b0;
        i_valid = 1'b1; i_instruction = insts[0]; i_tag = 32'd1;
        @(negedge i_clk);
        n_checks++;
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready0: o_ready=%0b, need 1", o_ready); end
        @(posedge i_clk); #1;
        i_instruction = insts[1]; i_tag = 32'd2;
        @(negedge i_clk);
        n_checks++;
        if ({o_ready, o_valid} !== 2'b11) begin n_fail++; $display("FAIL bp_ready1: ready,valid=%b, need 11", {o_ready, o_valid}); end
        @(posedge i_clk); #1;
        i_instruction = insts[2]; i_tag = 32'd3;
        @(negedge i_clk);
        n_checks++;
        if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: o_ready=%0b, need 0", o_ready); end
        @(posedge i_clk); #1;
        i_ready = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if ({o_ready, o_tag} !== {1'b0, 32'd1}) begin n_fail++; $display("FAIL bp_release: ready=%0b tag=%0d, need 0 1", o_ready, o_tag); end
        @(posedge i_clk); #1;
        @(negedge i_clk);
        n_checks++;
        if ({o_ready, o_tag} !== {1'b1, 32'd2}) begin n_fail++; $display("FAIL bp_reopen: ready=%0b tag=%0d, need 1 2", o_ready, o_tag); end
        @(posedge i_clk); #1;
        send_one(insts[3], 32'd4);
        drain();
        n_checks++;
        if (got_q.size() !== 4 || exp_q.size() !== 4) begin
            n_fail++;
            $display("FAIL bp_count: got %0d expected-queue %0d, need 4", got_q.size(), exp_q.size());
        end
        for (int k = 1; k <= 4 && got_q.size() > 0 && exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g !== e || g[67:36] !== 32'(k)) begin
                n_fail++;
                $display("FAIL bp_order[%0d]: got %h, need %h (tag %0d)", k, g, e, k);
            end
        end
        clear_queues();
    endtask

    task automatic test_zicsr();
        logic [31:0] exp_imm;
        logic [2:0]  exp_ty;
`ifdef IMMEDIATE_EXTEND_ZICSR_EN
        exp_imm = 32'd5; exp_ty = 3'd6;
`else
        exp_imm = 32'd0; exp_ty = 3'd0;
`endif
        i_ready = 1'b1;
        send_one(32'h3002D073, 32'd40);
        @(negedge i_clk);
        n_checks++;
        if ({o_valid, o_immediate, o_immType, o_illegal} !== {1'b1, exp_imm, exp_ty, 1'b0}) begin
            n_fail++;
            $display("FAIL csr_zimm: valid=%0b imm=%h type=%0d ill=%0b, need 1 %h %0d 0",
                     o_valid, o_immediate, o_immType, o_illegal, exp_imm, exp_ty);
        end
        @(posedge i_clk); #1;
        send_one(32'h00000073, 32'd41);
        @(negedge i_clk);
        n_checks++;
        if ({o_valid, o_immediate, o_immType, o_illegal} !== {1'b1, 32'h0, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL system_f3_zero: valid=%0b imm=%h type=%0d ill=%0b, need 1 0 0 0",
                     o_valid, o_immediate, o_immType, o_illegal);
        end
        drain();
        clear_queues();
    endtask

    task automatic test_random();
        logic [6:0]  ops [16];
        logic [31:0] rnd;
        logic [67:0] held;
        logic [67:0] e;
        logic [67:0] g;
        logic [63:0] e64;
        logic [63:0] g64;
        bit          hold_prev = 1'b0;
        ops = '{7'h03, 7'h0F, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37,
                7'h17, 7'h6F, 7'h33, 7'h3B, 7'h73, 7'h00, 7'h7F, 7'h2B};
        clear_queues();
        for (int c = 0; c < 400; c++) begin
            rnd = $urandom();
            i_instruction = {rnd[31:7], ops[$urandom_range(0, 15)]};
            i_tag   = 32'(c + 1000);
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 2) != 0);
            @(negedge i_clk);
            if (hold_prev) begin
                n_checks++;
                if ({o_tag, o_illegal, o_immType, o_immediate} !== held) begin
                    n_fail++;
                    $display("FAIL rand_stable[%0d]: outputs %h changed while stalled, need %h",
                             c, {o_tag, o_illegal, o_immType, o_immediate}, held);
                end
            end
            hold_prev = o_valid && !i_ready;
            held = {o_tag, o_illegal, o_immType, o_immediate};
            @(posedge i_clk); #1;
        end
        drain();
        n_checks++;
        if (got_q.size() !== exp_q.size() || got64_q.size() !== exp64_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d/%0d expected %0d/%0d",
                     got_q.size(), got64_q.size(), exp_q.size(), exp64_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL rand_entry32: got %h, need %h", g, e); end
        end
        while (got64_q.size() > 0 && exp64_q.size() > 0) begin
            e64 = exp64_q.pop_front();
            g64 = got64_q.pop_front();
            n_checks++;
            if (g64 !== e64) begin n_fail++; $display("FAIL rand_imm64: got %h, need %h", g64, e64); end
        end
        n_checks++;
        if (o_illegalCount !== exp_cnt) begin
            n_fail++;
            $display("FAIL rand_counter: cnt=%0d, need %0d", o_illegalCount, exp_cnt);
        end
        clear_queues();
    endtask

    task automatic test_reset_midstream();
        i_ready = 1'b0;
        send_one(32'h00000000, 32'd50);
        send_one(32'h123450B7, 32'd51);
        @(negedge i_clk);
        n_checks++;
        if ({o_valid, o_ready, o_illegalCount == 16'h0} !== 3'b100) begin
            n_fail++;
            $display("FAIL mid_full: valid=%0b ready=%0b cnt=%0d, need 1 0 nonzero", o_valid, o_ready, o_illegalCount);
        end
        #2 i_arst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_valid, o_ready, o_illegalCount, o_tag} !== {1'b0, 1'b1, 16'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%0b ready=%0b cnt=%0d tag=%0d, need 0 1 0 0",
                     o_valid, o_ready, o_illegalCount, o_tag);
        end
        @(negedge i_clk) i_arst_n = 1'b1;
        clear_queues();
        @(posedge i_clk); #1;
        i_ready = 1'b1;
        send_one(32'h001000EF, 32'd52);
        @(negedge i_clk);
        n_checks++;
        if ({o_valid, o_tag, o_immediate} !== {1'b1, 32'd52, 32'h00000800}) begin
            n_fail++;
            $display("FAIL post_reset: valid=%0b tag=%0d imm=%h, need 1 52 00000800", o_valid, o_tag, o_immediate);
        end
        drain();
        clear_queues();
    endtask

    initial begin
        test_reset();
        test_load_branch();
        test_store_u_j();
        test_illegal();
        test_backpressure();
        test_zicsr();
        test_random();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
